// File: rtl/ling_adder_pipe.sv
// ling_adder_pipe: three-stage pipelined Ling adder with valid/ready handshake.
//   S1 registers bitwise generate/propagate/half-sum and the carry-in.
//   S2 registers the Ling pseudo-carries H. They are built per 8-bit group,
//      and a Kogge-Stone prefix across the groups supplies each group's carry-in.
//   S3 registers sum, cout and, optionally, ovf.
// Optional feature: define LING_OVF_EN to add the two's-complement overflow port.
module ling_adder_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef LING_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Element 0 of the group arrays is the carry-in, treated as a virtual group.
  // Element k (k >= 1) is the data group k-1. The topmost data group never
  // needs its own group terms, because nothing sits above it.
  localparam int GROUPS = WIDTH / 8;

  logic             adv;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_g;
  logic [WIDTH-1:0] s1_p;
  logic [WIDTH-1:0] s1_x;
  logic             s1_cin;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_h;
  logic [WIDTH-1:0] s2_p;
  logic [WIDTH-1:0] s2_x;
  logic             s2_cin;

  logic [GROUPS-1:0] grp_g;
  logic [GROUPS-1:0] grp_p;
  logic [GROUPS-1:0] pfx_g;
  logic [GROUPS-1:0] pfx_p;
  logic [GROUPS-1:0] nxt_g;
  logic [GROUPS-1:0] nxt_p;
  logic [WIDTH-1:0]  h_next;

  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_next;
  logic             cout_next;

`ifdef LING_OVF_EN
  // When the operand sign bits agree, x is 0 there and g carries that sign.
  logic s2_sign;
  logic ovf_next;
`endif

  // The whole pipe moves only when the output slot is free or being drained.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !rst;

  // Group generate/propagate, followed by a parallel prefix across groups.
  always_comb begin
    // NOTE: every variable gets a default at the top so no path can infer a latch.
    grp_g = '0;
    grp_p = '0;
    pfx_g = '0;
    pfx_p = '0;
    nxt_g = '0;
    nxt_p = '0;
    grp_g[0] = s1_cin;
    grp_p[0] = s1_cin;
    for (int k = 1; k < GROUPS; k++) begin
      for (int j = 0; j < 8; j++) begin
        grp_g[k] = s1_g[8*(k-1)+j] | (s1_p[8*(k-1)+j] & grp_g[k]);
      end
      grp_p[k] = &s1_p[8*(k-1) +: 8];
    end
    pfx_g = grp_g;
    pfx_p = grp_p;
    for (int d = 1; d < GROUPS; d = d * 2) begin
      nxt_g = pfx_g;
      nxt_p = pfx_p;
      for (int k = d; k < GROUPS; k++) begin
        nxt_g[k] = pfx_g[k] | (pfx_p[k] & pfx_g[k-d]);
        nxt_p[k] = pfx_p[k] & pfx_p[k-d];
      end
      pfx_g = nxt_g;
      pfx_p = nxt_p;
    end
  end

  // Ling recurrence inside each group: H_i = g_i | p_{i-1} & H_{i-1}.
  // The first bit of a group takes the group carry-in as p_{i-1} & H_{i-1}.
  always_comb begin
    h_next = '0;
    for (int k = 0; k < GROUPS; k++) begin
      h_next[8*k] = s1_g[8*k] | pfx_g[k];
      for (int j = 1; j < 8; j++) begin
        h_next[8*k+j] = s1_g[8*k+j] | (s1_p[8*k+j-1] & h_next[8*k+j-1]);
      end
    end
  end

  // Recover real carries from the pseudo-carries: c_i = p_{i-1} & H_{i-1},
  // and c_0 is the carry-in itself.
  assign carry     = {s2_p[WIDTH-2:0] & s2_h[WIDTH-2:0], s2_cin};
  assign sum_next  = s2_x ^ carry;
  assign cout_next = s2_p[WIDTH-1] & s2_h[WIDTH-1];

`ifdef LING_OVF_EN
  assign ovf_next = !s2_x[WIDTH-1] && (sum_next[WIDTH-1] != s2_sign);
`endif

  // Control path: stage valid bits and visible outputs, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
`ifdef LING_OVF_EN
      ovf       <= 1'b0;
`endif
    end else if (adv) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      sum       <= sum_next;
      cout      <= cout_next;
`ifdef LING_OVF_EN
      ovf       <= ovf_next;
`endif
    end
  end

  // Internal datapath stages: advance in lockstep with the valid bits.
  always_ff @(posedge clk) begin
    // NOTE: internal data registers are not reset; their valid bits already mark them meaningless.
    if (adv) begin
      s1_g   <= a & b;
      s1_p   <= a | b;
      s1_x   <= a ^ b;
      s1_cin <= cin;
      s2_h   <= h_next;
      s2_p   <= s1_p;
      s2_x   <= s1_x;
      s2_cin <= s1_cin;
`ifdef LING_OVF_EN
      s2_sign <= s1_g[WIDTH-1];
`endif
    end
  end

endmodule
